down_counter16: RTL

//  Loadable down-counter/timer; the decrementing counterpart of the 16-bit incrementer.

---
 rtl/down_counter16.sv | 87 ++++++++
 1 files changed

// File: rtl/down_counter16.sv
// down_counter16: loadable down-counter/timer with start/busy/done handshake.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload from the last loaded value and keep running after each done.
module down_counter16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] count_nx, diff, eff;
    logic b;
    logic busy_nx;
    // Ripple half-subtractor chain; the final borrow is dropped since 0 is never decremented.
    always_comb begin
        b = 1'b1;
        diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = count[i] ^ b;
            b = ~count[i] & b;
        end
    end
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
    always_ff @(posedge clk)
        if (rst)
            reload <= '0;
        else if (state == IDLE && load)
            reload <= load_val;
`endif
    assign eff = load ? load_val : count;
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE: begin
                count_nx = eff;
                if (start)
                    state_nx = (eff != '0) ? RUN : DONE;
            end
            RUN:
                if (stop)
                    state_nx = IDLE;
                else if (!pause) begin
                    count_nx = diff;
                    if (count == WIDTH'(1))
                        state_nx = DONE;
                end
            DONE: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                count_nx = reload;
                state_nx = (reload != '0) ? RUN : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    assign busy_nx = (state_nx == RUN) || (state_nx == DONE);
`else
    assign busy_nx = (state_nx == RUN);
`endif
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            busy  <= busy_nx;
            done  <= (state_nx == DONE);
        end
    assign zero = (count == '0);
endmodule
